// File: rtl/s2p_debounce.sv
// Per-bit debounce filter for the serial-to-parallel expander word.
// Produces change pulses, sticky rise/fall events and a level interrupt.
module s2p_debounce #(
   parameter int              NBIT    = 64,
   parameter int              DEB_CNT = 3,
   parameter logic [NBIT-1:0] RST_VAL = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            tick,
   input  logic            din_vld,
   input  logic [NBIT-1:0] din,
   input  logic [NBIT-1:0] rise_en,
   input  logic [NBIT-1:0] fall_en,
   input  logic [NBIT-1:0] evt_clr,
   output logic [NBIT-1:0] dout,
   output logic [NBIT-1:0] chg_pulse,
   output logic [NBIT-1:0] evt_rise,
   output logic [NBIT-1:0] evt_fall,
   output logic            irq
);

   localparam int CW = (DEB_CNT > 1) ? $clog2(DEB_CNT + 1) : 1;
   localparam logic [CW-1:0] LAST = CW'(DEB_CNT - 1);
   localparam logic [CW-1:0] ONE  = CW'(1);

   logic [NBIT-1:0][CW-1:0] cnt_q, cnt_d;
   logic [NBIT-1:0]         dout_q, dout_d;
   logic [NBIT-1:0]         chg_q, chg_d;
   logic [NBIT-1:0]         rise_q, rise_d;
   logic [NBIT-1:0]         fall_q, fall_d;
   logic                    irq_q;
   logic                    upd;

   assign upd = tick & din_vld;

   always_comb begin
      dout_d = dout_q;
      cnt_d  = cnt_q;
      chg_d  = '0;
      if (upd) begin
         for (int i = 0; i < NBIT; i++) begin
            if (din[i] == dout_q[i]) begin
               cnt_d[i] = '0;
            end else if (cnt_q[i] == LAST) begin
               dout_d[i] = din[i];
               cnt_d[i]  = '0;
               chg_d[i]  = 1'b1;
            end else begin
               cnt_d[i] = cnt_q[i] + ONE;
            end
         end
      end
   end

   // Events set on the same edge dout changes; a set beats a clear.
   assign rise_d = (rise_q & ~evt_clr) | (chg_d & dout_d & rise_en);
   assign fall_d = (fall_q & ~evt_clr) | (chg_d & ~dout_d & fall_en);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         dout_q <= RST_VAL;
         chg_q  <= '0;
         rise_q <= '0;
         fall_q <= '0;
         irq_q  <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         dout_q <= dout_d;
         chg_q  <= chg_d;
         rise_q <= rise_d;
         fall_q <= fall_d;
         irq_q  <= |(rise_q | fall_q);
      end
   end

   assign dout      = dout_q;
   assign chg_pulse = chg_q;
   assign evt_rise  = rise_q;
   assign evt_fall  = fall_q;
   assign irq       = irq_q;

endmodule

// File: tb/tb_s2p_debounce.sv
// Scoreboard bench for s2p_debounce: stimulus pushes expected change
// and irq transitions, a negedge monitor pops and compares them.
module tb_s2p_debounce;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       tick;
   logic       din_vld;
   logic [7:0] din, rise_en, fall_en, evt_clr;
   logic [7:0] dout, chg_pulse, evt_rise, evt_fall;
   logic       irq;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   logic irq_prev = 1'b0;

   typedef struct {
      logic [7:0] d, c, r, f;
      int         cyc;
   } chg_t;

   typedef struct {
      logic v;
      int   cyc;
   } irq_t;

   chg_t chg_q[$];
   irq_t irq_q[$];

   s2p_debounce #(
      .NBIT   (8),
      .DEB_CNT(3),
      .RST_VAL(8'h00)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .tick     (tick),
      .din_vld  (din_vld),
      .din      (din),
      .rise_en  (rise_en),
      .fall_en  (fall_en),
      .evt_clr  (evt_clr),
      .dout     (dout),
      .chg_pulse(chg_pulse),
      .evt_rise (evt_rise),
      .evt_fall (evt_fall),
      .irq      (irq)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Monitor
   always @(negedge clk) begin
      if (rst_n) begin
         if (chg_pulse != 8'h00) begin
            if (chg_q.size() == 0) begin
               chk("unexpected_pulse", {24'h0, chg_pulse}, 32'h0);
            end else begin
               chg_t e;
               e = chg_q.pop_front();
               chk("pulse_cycle", cyc, e.cyc);
               chk("dout", {24'h0, dout}, {24'h0, e.d});
               chk("chg_pulse", {24'h0, chg_pulse}, {24'h0, e.c});
               chk("evt_rise", {24'h0, evt_rise}, {24'h0, e.r});
               chk("evt_fall", {24'h0, evt_fall}, {24'h0, e.f});
            end
         end
         if (irq != irq_prev) begin
            if (irq_q.size() == 0) begin
               chk("unexpected_irq", {31'h0, irq}, {31'h0, irq_prev});
            end else begin
               irq_t e;
               e = irq_q.pop_front();
               chk("irq_cycle", cyc, e.cyc);
               chk("irq_val", {31'h0, irq}, {31'h0, e.v});
            end
         end
      end
      irq_prev = irq;
   end

   // Called at a negedge; the next posedge is cyc+1.
   task automatic exp_chg(input logic [7:0] d, c, r, f);
      chg_t e;
      e.d = d; e.c = c; e.r = r; e.f = f; e.cyc = cyc + 1;
      chg_q.push_back(e);
   endtask

   task automatic exp_irq(input logic v);
      irq_t e;
      e.v = v; e.cyc = cyc + 2;
      irq_q.push_back(e);
   endtask

   task automatic do_tick(input logic [7:0] d, input logic [7:0] clr = 8'h00);
      din     = d;
      evt_clr = clr;
      tick    = 1'b1;
      @(negedge clk);
      tick    = 1'b0;
      evt_clr = 8'h00;
   endtask

   task automatic pulse_clr(input logic [7:0] clr);
      evt_clr = clr;
      @(negedge clk);
      evt_clr = 8'h00;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n   = 1'b0;
      tick    = 1'b0;
      din_vld = 1'b1;
      din     = 8'h00;
      rise_en = 8'h00;
      fall_en = 8'h00;
      evt_clr = 8'h00;
      idle(3);
      chk("rst_dout", {24'h0, dout}, 32'h0);
      chk("rst_chg", {24'h0, chg_pulse}, 32'h0);
      chk("rst_rise", {24'h0, evt_rise}, 32'h0);
      chk("rst_fall", {24'h0, evt_fall}, 32'h0);
      chk("rst_irq", {31'h0, irq}, 32'h0);
      rst_n = 1'b1;
      idle(1);

      // Async reset mid-count
      do_tick(8'hFF);
      do_tick(8'hFF);
      #2 rst_n = 1'b0;
      #1;
      chk("async_dout", {24'h0, dout}, 32'h0);
      chk("async_irq", {31'h0, irq}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      do_tick(8'hFF);
      do_tick(8'hFF);
      chk("cnt_cleared", {24'h0, dout}, 32'h0);
      do_tick(8'h00);

      // Stable rise with event
      rise_en = 8'h01;
      do_tick(8'h01);
      do_tick(8'h01);
      exp_chg(8'h01, 8'h01, 8'h01, 8'h00);
      exp_irq(1'b1);
      do_tick(8'h01);
      idle(2);

      // Back to 0 unmasked-fall-off, then clear
      do_tick(8'h00);
      do_tick(8'h00);
      exp_chg(8'h00, 8'h01, 8'h01, 8'h00);
      do_tick(8'h00);
      exp_irq(1'b0);
      pulse_clr(8'h01);
      chk("clr_rise", {24'h0, evt_rise}, 32'h0);
      idle(2);

      // Bounce restarts the count
      do_tick(8'h01);
      do_tick(8'h01);
      do_tick(8'h00);
      do_tick(8'h01);
      do_tick(8'h01);
      chk("bounce_hold", {24'h0, dout}, 32'h0);
      exp_chg(8'h01, 8'h01, 8'h01, 8'h00);
      exp_irq(1'b1);
      do_tick(8'h01);
      idle(2);

      // Clear race: set wins, irq stays high
      do_tick(8'h00);
      do_tick(8'h00);
      exp_chg(8'h00, 8'h01, 8'h01, 8'h00);
      do_tick(8'h00);
      do_tick(8'h01);
      do_tick(8'h01);
      exp_chg(8'h01, 8'h01, 8'h01, 8'h00);
      do_tick(8'h01, 8'h01);
      idle(2);
      chk("race_irq", {31'h0, irq}, 32'h1);
      exp_irq(1'b0);
      pulse_clr(8'h01);
      idle(2);

      // din_vld gating, counters frozen not cleared
      din_vld = 1'b0;
      repeat (10) do_tick(8'h81);
      chk("gated_dout", {24'h0, dout}, 32'h01);
      din_vld = 1'b1;
      do_tick(8'h81);
      do_tick(8'h81);
      exp_chg(8'h81, 8'h80, 8'h00, 8'h00);
      do_tick(8'h81);
      do_tick(8'h83);
      din_vld = 1'b0;
      repeat (3) do_tick(8'h83);
      din_vld = 1'b1;
      do_tick(8'h83);
      exp_chg(8'h83, 8'h02, 8'h00, 8'h00);
      do_tick(8'h83);

      // Masked fall on bit 3
      do_tick(8'h8B);
      do_tick(8'h8B);
      exp_chg(8'h8B, 8'h08, 8'h00, 8'h00);
      do_tick(8'h8B);
      do_tick(8'h83);
      do_tick(8'h83);
      exp_chg(8'h83, 8'h08, 8'h00, 8'h00);
      do_tick(8'h83);
      idle(2);
      chk("masked_irq", {31'h0, irq}, 32'h0);

      // Enabled fall on bit 3
      fall_en = 8'h08;
      do_tick(8'h8B);
      do_tick(8'h8B);
      exp_chg(8'h8B, 8'h08, 8'h00, 8'h00);
      do_tick(8'h8B);
      do_tick(8'h83);
      do_tick(8'h83);
      exp_chg(8'h83, 8'h08, 8'h00, 8'h08);
      exp_irq(1'b1);
      do_tick(8'h83);
      fall_en = 8'h00;
      idle(3);
      chk("fall_sticky", {24'h0, evt_fall}, 32'h08);
      exp_irq(1'b0);
      pulse_clr(8'h08);
      idle(3);

      chk("chg_q_drained", chg_q.size(), 0);
      chk("irq_q_drained", irq_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
